regfile_sb: RTL and testbench

- Parametrised successor of the CPU's 16x16 two-read/one-write register file.
- Adds:
  - a second write port (ALU writeback + load/IO writeback);
  - optional write-to-read bypass;
  - synchronous clear via reset instead of file preload;
  - a per-register pending scoreboard so the control unit can stall on operands whose load has not returned.
- Sits between the decoder/control unit and the datapath muxes.

---
 rtl/regfile_sb.sv | 128 ++++++++++++
 tb/tb_regfile_sb.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Register file with two read ports, two write ports (B wins a same-address tie),
// optional write-to-read bypass and a per-register load-pending scoreboard.
module regfile_sb #(
    parameter int WIDTH  = 16,
    parameter int AW     = 4,
    parameter bit BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic             rdy1,
    output logic             rdy2,
    input  logic             we_a,
    input  logic [AW-1:0]    wa_a,
    input  logic [WIDTH-1:0] wd_a,
    input  logic             we_b,
    input  logic [AW-1:0]    wa_b,
    input  logic [WIDTH-1:0] wd_b,
    input  logic             mark,
    input  logic [AW-1:0]    ma,
    output logic [AW:0]      pend_cnt,
    output logic             wcoll
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH-1:0]      r_pend;
    logic                  r_wcoll;

    logic [DEPTH-1:0]      w_wen_a;
    logic [DEPTH-1:0]      w_wen_b;
    logic [DEPTH-1:0]      w_mark;
    logic [DEPTH-1:0]      w_pend_nxt;
    logic                  w_coll_nxt;
    logic [1:0][WIDTH-1:0] w_rd;
    logic [1:0]            w_rdy;
    logic [AW:0]           w_cnt;

    // One-hot decode of both write ports and the mark port; bit 0 stays clear
    // so register 0 can never be written or marked.
    always_comb begin
        w_wen_a = '0;
        w_wen_b = '0;
        w_mark  = '0;
        for (int i = 1; i < DEPTH; i++) begin
            w_wen_a[i] = we_a && (wa_a == AW'(i));
            w_wen_b[i] = we_b && (wa_b == AW'(i));
            w_mark[i]  = mark && (ma == AW'(i));
        end
        // Mark is applied last so it beats a write to the same register.
        w_pend_nxt = (r_pend & ~(w_wen_a | w_wen_b)) | w_mark;
        w_coll_nxt = we_a && we_b && (wa_a == wa_b) && (wa_a != '0);
    end

    // NOTE: the storage array is reset explicitly because the file is cleared
    // by reset rather than preloaded; this rules out a RAM macro on purpose.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (w_wen_b[i]) begin
                    r_mem[i] <= wd_b;
                end else if (w_wen_a[i]) begin
                    r_mem[i] <= wd_a;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend  <= '0;
            r_wcoll <= 1'b0;
        end else begin
            r_pend  <= w_pend_nxt;
            r_wcoll <= w_coll_nxt;
        end
    end

    // Read ports: port B data has priority over port A when forwarding.
    always_comb begin
        w_rd  = '0;
        w_rdy = '1;
        for (int p = 0; p < 2; p++) begin
            logic [AW-1:0] addr;
            addr     = (p == 0) ? ra1 : ra2;
            w_rd[p]  = r_mem[addr];
            w_rdy[p] = !r_pend[addr];
            if (BYPASS) begin
                if (w_wen_b[addr]) begin
                    w_rd[p]  = wd_b;
                    w_rdy[p] = 1'b1;
                end else if (w_wen_a[addr]) begin
                    w_rd[p]  = wd_a;
                    w_rdy[p] = 1'b1;
                end
            end
            if (addr == '0) begin
                w_rd[p]  = '0;
                w_rdy[p] = 1'b1;
            end
        end
    end

    always_comb begin
        w_cnt = '0;
        for (int i = 1; i < DEPTH; i++) begin
            w_cnt = w_cnt + {{AW{1'b0}}, r_pend[i]};
        end
    end

    assign rd1      = w_rd[0];
    assign rd2      = w_rd[1];
    assign rdy1     = w_rdy[0];
    assign rdy2     = w_rdy[1];
    assign pend_cnt = w_cnt;
    assign wcoll    = r_wcoll;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench: a BYPASS=1 and a BYPASS=0 instance share stimulus and are
// compared every cycle against an array-based model, plus directed scenarios.
module tb_regfile_sb;

    localparam int W = 16;
    localparam int A = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [A-1:0] ra1 = '0, ra2 = '0;
    logic         we_a = 1'b0, we_b = 1'b0, mark = 1'b0;
    logic [A-1:0] wa_a = '0, wa_b = '0, ma = '0;
    logic [W-1:0] wd_a = '0, wd_b = '0;

    logic [W-1:0] rd1_1, rd2_1, rd1_0, rd2_0;
    logic         rdy1_1, rdy2_1, rdy1_0, rdy2_0;
    logic [A:0]   cnt_1, cnt_0;
    logic         wcoll_1, wcoll_0;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    regfile_sb #(.WIDTH(W), .AW(A), .BYPASS(1'b1)) u_byp (
        .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1_1), .rd2(rd2_1),
        .rdy1(rdy1_1), .rdy2(rdy2_1), .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
        .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b), .mark(mark), .ma(ma),
        .pend_cnt(cnt_1), .wcoll(wcoll_1));

    regfile_sb #(.WIDTH(W), .AW(A), .BYPASS(1'b0)) u_nob (
        .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1_0), .rd2(rd2_0),
        .rdy1(rdy1_0), .rdy2(rdy2_0), .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
        .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b), .mark(mark), .ma(ma),
        .pend_cnt(cnt_0), .wcoll(wcoll_0));

    always #5 clk = ~clk;

    // Behavioural model: plain arrays updated by the architectural rules.
    logic [W-1:0] m_mem  [16];
    bit           m_pend [16];
    bit           m_wcoll;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                m_mem[i]  = '0;
                m_pend[i] = 1'b0;
            end
            m_wcoll = 1'b0;
        end else begin
            m_wcoll = we_a && we_b && (wa_a == wa_b) && (wa_a != 0);
            if (we_a && wa_a != 0) begin m_mem[wa_a] = wd_a; m_pend[wa_a] = 1'b0; end
            if (we_b && wa_b != 0) begin m_mem[wa_b] = wd_b; m_pend[wa_b] = 1'b0; end
            if (mark && ma != 0) m_pend[ma] = 1'b1;
        end
    end

    function automatic logic [W-1:0] exp_rd(input logic [A-1:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && we_b && wa_b == a) return wd_b;
        if (byp && we_a && wa_a == a) return wd_a;
        return m_mem[a];
    endfunction

    function automatic bit exp_rdy(input logic [A-1:0] a, input bit byp);
        if (a == 0) return 1'b1;
        if (byp && ((we_a && wa_a == a) || (we_b && wa_b == a))) return 1'b1;
        return !m_pend[a];
    endfunction

    function automatic int exp_cnt();
        int n = 0;
        for (int i = 1; i < 16; i++) n += int'(m_pend[i]);
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    // Cycle-by-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (chk_en && !reset) begin
            check("byp_rd1",  rd1_1,   exp_rd(ra1, 1'b1));
            check("byp_rd2",  rd2_1,   exp_rd(ra2, 1'b1));
            check("byp_rdy1", rdy1_1,  exp_rdy(ra1, 1'b1));
            check("byp_rdy2", rdy2_1,  exp_rdy(ra2, 1'b1));
            check("byp_cnt",  cnt_1,   exp_cnt());
            check("byp_coll", wcoll_1, m_wcoll);
            check("nob_rd1",  rd1_0,   exp_rd(ra1, 1'b0));
            check("nob_rd2",  rd2_0,   exp_rd(ra2, 1'b0));
            check("nob_rdy1", rdy1_0,  exp_rdy(ra1, 1'b0));
            check("nob_rdy2", rdy2_0,  exp_rdy(ra2, 1'b0));
            check("nob_cnt",  cnt_0,   exp_cnt());
            check("nob_coll", wcoll_0, m_wcoll);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we_a = 1'b0; we_b = 1'b0; mark = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        chk_en = 1'b1;

        // Reset state
        ra1 = 4'd5; ra2 = 4'd15; #1;
        check("rst_rd1", rd1_1, 16'h0);
        check("rst_rd2", rd2_0, 16'h0);
        check("rst_rdy", {rdy1_1, rdy2_1, rdy1_0, rdy2_0}, 4'hF);
        check("rst_cnt", cnt_1, 5'd0);
        tick();

        // Single write with and without bypass, then a write to register 0
        we_a = 1'b1; wa_a = 4'd3; wd_a = 16'h1234; ra1 = 4'd3; #1;
        check("wr_byp_same", rd1_1, 16'h1234);
        check("wr_nob_same", rd1_0, 16'h0000);
        tick(); idle(); #1;
        check("wr_nob_next", rd1_0, 16'h1234);
        we_a = 1'b1; wa_a = 4'd0; wd_a = 16'hFFFF; ra1 = 4'd0; #1;
        check("wr0_byp_same", rd1_1, 16'h0000);
        tick(); idle(); #1;
        check("wr0_nob_next", rd1_0, 16'h0000);
        tick();

        // Dual-write collision
        we_a = 1'b1; wa_a = 4'd7; wd_a = 16'hAAAA;
        we_b = 1'b1; wa_b = 4'd7; wd_b = 16'h5555;
        tick(); idle(); ra1 = 4'd7; #1;
        check("coll_data", rd1_0, 16'h5555);
        check("coll_pulse", wcoll_1, 1'b1);
        check("model_r7", m_mem[7], 16'h5555);
        tick();
        check("coll_gone", wcoll_1, 1'b0);

        // Scoreboard mark then load return
        mark = 1'b1; ma = 4'd9;
        tick(); idle(); ra1 = 4'd9; #1;
        check("mark_cnt", cnt_1, 5'd1);
        check("mark_rdy", rdy1_1, 1'b0);
        we_b = 1'b1; wa_b = 4'd9; wd_b = 16'h00FF; #1;
        check("ret_byp_rdy", rdy1_1, 1'b1);
        check("ret_byp_rd",  rd1_1,  16'h00FF);
        check("ret_nob_rdy", rdy1_0, 1'b0);
        tick(); idle(); #1;
        check("ret_cnt", cnt_0, 5'd0);
        check("ret_rd",  rd1_0, 16'h00FF);

        // Mark and write on the same edge
        mark = 1'b1; ma = 4'd4; we_a = 1'b1; wa_a = 4'd4; wd_a = 16'h0042;
        tick(); idle(); ra1 = 4'd4; #1;
        check("mw_data", rd1_0, 16'h0042);
        check("mw_rdy",  rdy1_0, 1'b0);
        check("mw_cnt",  cnt_1, 5'd1);
        mark = 1'b1; ma = 4'd0;
        tick(); idle(); #1;
        check("mark0_cnt", cnt_1, 5'd1);
        for (int i = 1; i < 16; i++) begin
            mark = 1'b1; ma = A'(i);
            tick();
        end
        idle(); #1;
        check("mark_all_cnt", cnt_1, 5'd15);
        check("model_cnt", exp_cnt(), 15);
        tick();

        // Randomised traffic with occasional asynchronous resets
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            we_a = 1'($urandom_range(0, 1));
            we_b = 1'($urandom_range(0, 1));
            mark = ($urandom_range(0, 2) == 0);
            wa_a = A'($urandom);
            wa_b = ($urandom_range(0, 3) == 0) ? wa_a : A'($urandom);
            ma   = ($urandom_range(0, 3) == 0) ? wa_b : A'($urandom);
            wd_a = W'($urandom);
            wd_b = W'($urandom);
            ra1  = ($urandom_range(0, 2) == 0) ? wa_b : A'($urandom);
            ra2  = ($urandom_range(0, 2) == 0) ? wa_a : A'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #2 reset = 1'b1;
                #1;
                check("rand_rst_cnt", cnt_1, 5'd0);
                @(posedge clk);
                #1 reset = 1'b0;
            end else begin
                tick();
            end
        end

        // Asynchronous reset between edges with live state
        do_reset();
        we_a = 1'b1; wa_a = 4'd2; wd_a = 16'h1111;
        we_b = 1'b1; wa_b = 4'd5; wd_b = 16'h2222;
        tick(); idle();
        for (int i = 10; i < 13; i++) begin
            mark = 1'b1; ma = A'(i);
            tick();
        end
        idle();
        we_a = 1'b1; wa_a = 4'd6; wd_a = 16'h0001;
        we_b = 1'b1; wa_b = 4'd6; wd_b = 16'h0002;
        tick(); idle(); ra1 = 4'd2; ra2 = 4'd6; #1;
        check("pre_cnt",  cnt_1,   5'd3);
        check("pre_coll", wcoll_0, 1'b1);
        check("pre_rd1",  rd1_0,   16'h1111);
        #1 reset = 1'b1;
        #1;
        check("arst_rd1",  rd1_1,   16'h0);
        check("arst_rd2",  rd2_0,   16'h0);
        check("arst_cnt",  cnt_0,   5'd0);
        check("arst_coll", wcoll_1, 1'b0);
        we_a = 1'b1; wa_a = 4'd3; wd_a = 16'hBEEF;
        tick();
        reset = 1'b0; idle(); ra1 = 4'd3; #1;
        check("arst_nowrite_byp", rd1_1, 16'h0);
        check("arst_nowrite_nob", rd1_0, 16'h0);
        tick();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
